// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for the shared IM/data RAM.
// Accepts one request at a time, computes the effective word address,
// drives registered RAM strobes and returns a single-cycle response.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | RAM strobe active (1 cycle for stores, READ_WAIT cycles for loads)
// RESP   | resp_valid pulse, no request accepted
module mem_access_unit #(
  parameter int unsigned READ_WAIT = 1,
  parameter int unsigned ADDR_MAX  = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_order,
  input  logic [31:0] req_base,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wena,
  output logic        mem_rena,
  output logic [31:0] mem_order,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  logic          ready_n, rvalid_n, err_n, wena_n, rena_n;
  logic [31:0]   rdata_n, order_n, addr_n, din_n;
  logic [31:0]   ea;
  logic [5:0]    req_op;
  logic          op_legal, op_store, addr_bad;
  logic [31:0]   load_ext;

  assign req_op   = req_order[31:26];
  assign ea       = req_base + {{16{req_order[15]}}, req_order[15:0]};
  assign addr_bad = (ea > 32'(ADDR_MAX));

  // Decode the incoming opcode into legal / store classes.
  always_comb begin
    op_legal = 1'b1;
    op_store = 1'b0;
    case (req_op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_store = 1'b0;
      OP_SB, OP_SH, OP_SW:                 op_store = 1'b1;
      default:                             op_legal = 1'b0;
    endcase
  end

  // Extend RAM read data; the latched order word still sits on mem_order during ACCESS.
  always_comb begin
    load_ext = mem_data_out;
    case (mem_order[31:26])
      OP_LB:   load_ext = {{24{mem_data_out[7]}}, mem_data_out[7:0]};
      OP_LBU:  load_ext = {24'd0, mem_data_out[7:0]};
      OP_LH:   load_ext = {{16{mem_data_out[15]}}, mem_data_out[15:0]};
      OP_LHU:  load_ext = {16'd0, mem_data_out[15:0]};
      default: load_ext = mem_data_out;
    endcase
  end

  // Next-state and next registered-output logic.
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    ready_n    = 1'b0;
    rvalid_n   = 1'b0;
    rdata_n    = 32'd0;
    err_n      = 1'b0;
    wena_n     = 1'b0;
    rena_n     = 1'b0;
    order_n    = 32'd0;
    addr_n     = mem_addr;
    din_n      = mem_data_in;
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (req_valid && req_ready) begin
          ready_n = 1'b0;
          if (!op_legal || addr_bad || (op_store && ea == 32'd0)) begin
            state_n  = RESP;
            rvalid_n = 1'b1;
            err_n    = 1'b1;
          end else begin
            state_n    = ACCESS;
            order_n    = req_order;
            addr_n     = ea;
            wena_n     = op_store;
            rena_n     = !op_store;
            wait_cnt_n = CW'(READ_WAIT - 1);
            if (op_store) din_n = req_wdata;
          end
        end
      end
      ACCESS: begin
        if (mem_wena) begin
          state_n  = RESP;
          rvalid_n = 1'b1;
        end else if (wait_cnt == '0) begin
          state_n  = RESP;
          rvalid_n = 1'b1;
          rdata_n  = load_ext;
        end else begin
          wait_cnt_n = wait_cnt - CW'(1);
          rena_n     = 1'b1;
          order_n    = mem_order;
        end
      end
      RESP: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything, including ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_err    <= 1'b0;
      mem_wena    <= 1'b0;
      mem_rena    <= 1'b0;
      mem_order   <= 32'd0;
      mem_addr    <= 32'd0;
      mem_data_in <= 32'd0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_cnt_n;
      req_ready   <= ready_n;
      resp_valid  <= rvalid_n;
      resp_rdata  <= rdata_n;
      resp_err    <= err_n;
      mem_wena    <= wena_n;
      mem_rena    <= rena_n;
      mem_order   <= order_n;
      mem_addr    <= addr_n;
      mem_data_in <= din_n;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed spec scenarios plus random loads/stores
// checked against a transaction-level reference model and a RAM model.
module tb_mem_access_unit;
  localparam int RW   = 3;
  localparam int AMAX = 10000;

  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011,
                         LBU = 6'b100100, LHU = 6'b100101,
                         SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, resp_valid, resp_err, mem_wena, mem_rena;
  logic [31:0] req_order, req_base, req_wdata, resp_rdata;
  logic [31:0] mem_order, mem_addr, mem_data_in, mem_data_out;
  logic [31:0] ram [0:AMAX];
  logic [31:0] ref_mem [0:AMAX];
  logic        ram_init;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.READ_WAIT(RW), .ADDR_MAX(AMAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_order(req_order), .req_base(req_base), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wena(mem_wena), .mem_rena(mem_rena), .mem_order(mem_order),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  function automatic logic [31:0] init_val(input int a);
    if (a == 200) return 32'd999;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  assign mem_data_out = (mem_addr <= 32'(AMAX)) ? ram[mem_addr[13:0]] : 32'd0;

  // RAM model: combinational read, write at posedge, address 0 discarded.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i <= AMAX; i++) ram[i] <= init_val(i);
    end else if (mem_wena && mem_addr != 32'd0 && mem_addr <= 32'(AMAX)) begin
      case (mem_order[31:26])
        SB:      ram[mem_addr[13:0]][7:0]  <= mem_data_in[7:0];
        SH:      ram[mem_addr[13:0]][15:0] <= mem_data_in[15:0];
        default: ram[mem_addr[13:0]]       <= mem_data_in;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction: reference prediction, drive, then cycle-by-cycle observation.
  task automatic txn(input logic [31:0] order, input logic [31:0] base,
                     input logic [31:0] wdata, output logic [31:0] got);
    logic [5:0]  op;
    logic [31:0] ea, w, exp_rdata;
    int          v, exp_lat, lat, wc, rc, n;
    bit          ld, st, er;
    op = order[31:26];
    ea = base + 32'($signed(order[15:0]));
    ld = (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
    st = (op == SB) || (op == SH) || (op == SW);
    er = !(ld || st) || (ea > 32'(AMAX)) || (st && ea == 32'd0);
    exp_rdata = 32'd0;
    if (!er && ld) begin
      w = ref_mem[ea[13:0]];
      case (op)
        LB:  begin v = int'(w % 256);   if (v >= 128)   v = v - 256;   exp_rdata = 32'(v); end
        LBU: exp_rdata = w % 256;
        LH:  begin v = int'(w % 65536); if (v >= 32768) v = v - 65536; exp_rdata = 32'(v); end
        LHU: exp_rdata = w % 65536;
        default: exp_rdata = w;
      endcase
    end
    if (!er && st) begin
      case (op)
        SB:      ref_mem[ea[13:0]] = (ref_mem[ea[13:0]] & ~32'hFF)   | (wdata & 32'hFF);
        SH:      ref_mem[ea[13:0]] = (ref_mem[ea[13:0]] & ~32'hFFFF) | (wdata & 32'hFFFF);
        default: ref_mem[ea[13:0]] = wdata;
      endcase
    end
    exp_lat = er ? 1 : (st ? 2 : 1 + RW);

    @(negedge clk);
    req_valid = 1'b1; req_order = order; req_base = base; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; wc = 0; rc = 0;
    while (!resp_valid && lat < 20) begin
      chk("quiet_resp_zero", {31'd0, resp_err, resp_rdata}, 64'd0);
      if (mem_wena) begin
        wc++;
        chk("st_addr", 64'(mem_addr), 64'(ea));
        chk("st_data", 64'(mem_data_in), 64'(wdata));
        chk("st_order", 64'(mem_order), 64'(order));
      end
      if (mem_rena) begin
        rc++;
        chk("ld_addr", 64'(mem_addr), 64'(ea));
        chk("ld_order", 64'(mem_order), 64'(order));
      end
      if (!mem_wena && !mem_rena) chk("order_idle", 64'(mem_order), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("resp_valid", 64'(resp_valid), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("rdata", 64'(resp_rdata), 64'(exp_rdata));
    chk("err", 64'(resp_err), 64'(er));
    chk("ready_in_resp", 64'(req_ready), 64'd0);
    chk("strobes_in_resp", {62'd0, mem_wena, mem_rena}, 64'd0);
    chk("wena_cycles", 64'(wc), 64'((st && !er) ? 1 : 0));
    chk("rena_cycles", 64'(rc), 64'((ld && !er) ? RW : 0));
    got = resp_rdata;
    @(posedge clk); #1;
    chk("resp_one_cycle", 64'(resp_valid), 64'd0);
    chk("ready_after", 64'(req_ready), 64'd1);
    chk("post_resp_zero", {31'd0, resp_err, resp_rdata}, 64'd0);
  endtask

  logic [5:0] ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  initial begin
    logic [31:0] got, base;
    logic [15:0] imm;
    logic [5:0]  op;
    int          pulses;

    rst = 1'b1; ram_init = 1'b1; req_valid = 1'b0;
    req_order = '0; req_base = '0; req_wdata = '0;
    for (int i = 0; i <= AMAX; i++) ref_mem[i] = init_val(i);
    repeat (2) @(posedge clk);
    #1;
    ram_init = 1'b0;
    chk("rst_flags", {59'd0, req_ready, resp_valid, resp_err, mem_wena, mem_rena}, 64'd0);
    chk("rst_order", 64'(mem_order), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_rdata", 64'(resp_rdata), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    txn(mk(SW, 16'd5), 32'd100, 32'hDEADBEEF, got);
    txn(mk(SB, 16'd5), 32'd100, 32'h000000A5, got);
    txn(mk(LBU, 16'd5), 32'd100, 32'd0, got);
    chk("lbu_105", 64'(got), 64'h000000A5);
    txn(mk(LB, 16'd5), 32'd100, 32'd0, got);
    chk("lb_105", 64'(got), 64'hFFFFFFA5);
    txn(mk(LW, 16'd5), 32'd100, 32'd0, got);
    chk("lw_105", 64'(got), 64'hDEADBEA5);
    txn(mk(LH, 16'd0), 32'd200, 32'd0, got);
    chk("lh_200", 64'(got), 64'h000003E7);
    txn(mk(SW, 16'hFFFD), 32'd3, 32'h12345678, got);
    txn(mk(6'b111111, 16'd4), 32'd100, 32'd0, got);
    txn(mk(LW, 16'd0), 32'd10001, 32'd0, got);
    txn(mk(SW, 16'd0), 32'd10000, 32'hCAFEF00D, got);
    txn(mk(LW, 16'hFFFF), 32'd10001, 32'd0, got);
    chk("lw_10000", 64'(got), 64'hCAFEF00D);

    // Illegal request held high: only every other cycle is accepted.
    @(negedge clk);
    req_valid = 1'b1; req_order = mk(6'b111111, 16'd0); req_base = 32'd0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        pulses++;
        chk("held_ready_in_resp", 64'(req_ready), 64'd0);
        chk("held_err", 64'(resp_err), 64'd1);
      end
    end
    chk("held_pulses", 64'(pulses), 64'd3);
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk); #1;

    // Reset during load ACCESS: no response, ready returns after reset drops.
    @(negedge clk);
    req_valid = 1'b1; req_order = mk(LW, 16'd300); req_base = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midrst_rena", 64'(mem_rena), 64'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_flags", {59'd0, req_ready, resp_valid, resp_err, mem_wena, mem_rena}, 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_resp", 64'(resp_valid), 64'd0);
      chk("midrst_ready", 64'(req_ready), 64'd1);
    end

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 7)];
      else op = 6'($urandom_range(0, 63));
      base = 32'($urandom_range(0, 10050));
      imm  = 16'($urandom_range(0, 400) - 200);
      if ($urandom_range(0, 7) == 0) begin
        base = 32'($urandom_range(0, 50));
        imm  = 16'(-int'(base));
      end
      txn(mk(op, imm), base, $urandom, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
